adsr_envelope: RTL and testbench

Amplitude envelope generator and VCA that sits directly downstream of the waveform oscillators, using the same `step_in` sample-rate strobe. It tracks a note gate through attack/decay/sustain/release, producing an 8-bit unsigned envelope. It then scales the oscillator's signed 8-bit sample by that envelope for the mixer. One instance per voice.

---
 rtl/adsr_envelope.sv | 170 +++++++++++++++++
 tb/tb_adsr_envelope.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adsr_envelope.sv
// adsr_envelope
//   Per-voice ADSR amplitude envelope generator with a VCA stage.
//   The envelope advances only on sample-rate strobes. The oscillator sample
//   is scaled by the 8-bit envelope every clock.
//
// Ports
//   clk_in        : system clock
//   rst_in        : asynchronous active-high reset
//   step_in       : one-cycle sample-rate strobe (shared with the oscillator)
//   gate_in       : note gate, high while the key is held
//   attack_incr   : envelope increment per step in ATTACK
//   decay_decr    : envelope decrement per step in DECAY
//   sustain_level : sustain amplitude (upper byte of the sustain target)
//   release_decr  : envelope decrement per step in RELEASE
//   sample_in     : signed oscillator sample
//   sample_out    : signed enveloped sample (registered)
//   env_out       : current envelope, unsigned (registered from env[15:8])
//   busy_out      : high whenever the voice is not IDLE
module adsr_envelope (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              step_in,
  input  logic              gate_in,
  input  logic [15:0]       attack_incr,
  input  logic [15:0]       decay_decr,
  input  logic [7:0]        sustain_level,
  input  logic [15:0]       release_decr,
  input  logic signed [7:0] sample_in,
  output logic signed [7:0] sample_out,
  output logic [7:0]        env_out,
  output logic              busy_out
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] env_reg, env_next;
  logic        gate_q_reg, gate_q_next;

  logic        rise, fall;
  logic [15:0] sus_t;
  logic [16:0] atk_sum;
  logic [16:0] dec_diff;
  logic [16:0] rel_diff;
  logic signed [16:0] vca_product;

  assign sus_t = {sustain_level, 8'h00};
  assign rise  = gate_in & ~gate_q_reg;
  assign fall  = ~gate_in & gate_q_reg;

  // 17-bit arithmetic: bit 16 of the sum flags overflow, and bit 16 of each
  // difference flags a borrow (the result would have gone below zero).
  assign atk_sum  = {1'b0, env_reg} + {1'b0, attack_incr};
  assign dec_diff = {1'b0, env_reg} - {1'b0, decay_decr};
  assign rel_diff = {1'b0, env_reg} - {1'b0, release_decr};

  // ---------------------------------------------------------------------
  // State / envelope registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg  <= IDLE;
      env_reg    <= 16'h0000;
      gate_q_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      env_reg    <= env_next;
      gate_q_reg <= gate_q_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and envelope arithmetic, evaluated only on step cycles.
  // A gate-driven transition takes priority and leaves env untouched.
  // ---------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    env_next    = env_reg;
    gate_q_next = gate_q_reg;

    if (step_in) begin
      gate_q_next = gate_in;
      case (state_reg)
        IDLE: begin
          env_next = 16'h0000;
          if (rise) begin
            state_next = ATTACK;
          end
        end

        ATTACK: begin
          if (fall) begin
            state_next = RELEASE;
          end else if (atk_sum[16] || (atk_sum[15:0] == 16'hFFFF)) begin
            env_next   = 16'hFFFF;
            state_next = DECAY;
          end else begin
            env_next = atk_sum[15:0];
          end
        end

        DECAY: begin
          if (fall) begin
            state_next = RELEASE;
          end else if (dec_diff[16] || (dec_diff[15:0] <= sus_t)) begin
            // Clamped at the sustain target. This also covers a sustain
            // level raised above the current env during decay.
            env_next   = sus_t;
            state_next = SUSTAIN;
          end else begin
            env_next = dec_diff[15:0];
          end
        end

        SUSTAIN: begin
          if (fall) begin
            state_next = RELEASE;
          end else begin
            env_next = sus_t;
          end
        end

        RELEASE: begin
          if (rise) begin
            // Legato retrigger: attack resumes from the current env.
            state_next = ATTACK;
          end else if (rel_diff[16] || (rel_diff[15:0] == 16'h0000)) begin
            env_next   = 16'h0000;
            state_next = IDLE;
          end else begin
            env_next = rel_diff[15:0];
          end
        end

        default: begin
          state_next = IDLE;
          env_next   = 16'h0000;
        end
      endcase
    end
  end

  assign busy_out = (state_reg != IDLE);

  // ---------------------------------------------------------------------
  // VCA: signed sample times unsigned envelope. The envelope is widened
  // with a zero sign bit so that it is always treated as positive. Taking
  // bits [15:8] gives a floor shift by 8. The product magnitude never
  // exceeds 128*255, so the result fits without saturation.
  // ---------------------------------------------------------------------
  assign vca_product = $signed({{9{sample_in[7]}}, sample_in}) *
                       $signed({9'b0_0000_0000, env_out});

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      env_out    <= 8'h00;
      sample_out <= 8'sh00;
    end else begin
      env_out    <= env_reg[15:8];
      sample_out <= vca_product[15:8];
    end
  end

endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope
//   Directed and randomized checks of adsr_envelope against a behavioural
//   envelope model. The model works on plain integers and min/max rules.
module tb_adsr_envelope;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              step_in;
  logic              gate_in;
  logic [15:0]       attack_incr;
  logic [15:0]       decay_decr;
  logic [7:0]        sustain_level;
  logic [15:0]       release_decr;
  logic signed [7:0] sample_in;
  logic signed [7:0] sample_out;
  logic [7:0]        env_out;
  logic              busy_out;

  always #5 clk_in = ~clk_in;

  adsr_envelope dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .step_in       (step_in),
    .gate_in       (gate_in),
    .attack_incr   (attack_incr),
    .decay_decr    (decay_decr),
    .sustain_level (sustain_level),
    .release_decr  (release_decr),
    .sample_in     (sample_in),
    .sample_out    (sample_out),
    .env_out       (env_out),
    .busy_out      (busy_out)
  );

  localparam int M_IDLE    = 0;
  localparam int M_ATTACK  = 1;
  localparam int M_DECAY   = 2;
  localparam int M_SUSTAIN = 3;
  localparam int M_RELEASE = 4;

  int checks = 0;
  int errors = 0;

  int m_state;
  int m_env;
  int m_gate;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_env   = 0;
    m_gate  = 0;
  endtask

  // One step of the envelope, using the inputs as currently driven.
  task automatic model_step();
    int g, r, f, sus;
    g   = int'(gate_in);
    r   = (g == 1 && m_gate == 0) ? 1 : 0;
    f   = (g == 0 && m_gate == 1) ? 1 : 0;
    sus = int'(sustain_level) * 256;
    m_gate = g;
    case (m_state)
      M_IDLE: begin
        m_env = 0;
        if (r == 1) m_state = M_ATTACK;
      end
      M_ATTACK: begin
        if (f == 1) m_state = M_RELEASE;
        else begin
          m_env = imin(m_env + int'(attack_incr), 65535);
          if (m_env == 65535) m_state = M_DECAY;
        end
      end
      M_DECAY: begin
        if (f == 1) m_state = M_RELEASE;
        else begin
          m_env = imax(m_env - int'(decay_decr), sus);
          if (m_env == sus) m_state = M_SUSTAIN;
        end
      end
      M_SUSTAIN: begin
        if (f == 1) m_state = M_RELEASE;
        else m_env = sus;
      end
      default: begin
        if (r == 1) m_state = M_ATTACK;
        else begin
          m_env = imax(m_env - int'(release_decr), 0);
          if (m_env == 0) m_state = M_IDLE;
        end
      end
    endcase
  endtask

  function automatic int vca_expect(input int s, input int e);
    int p;
    p = s * e;
    return p >>> 8;
  endfunction

  // Compare all outputs against the model once the step has propagated.
  task automatic verify(input string tag);
    int e8;
    e8 = m_env / 256;
    check({tag, ".env"},  int'(env_out), e8);
    check({tag, ".busy"}, int'(busy_out), (m_state != M_IDLE) ? 1 : 0);
    check({tag, ".vca"},  int'($signed(sample_out)),
          vca_expect(int'(sample_in), e8));
  endtask

  // Strobe one step with the given gate level, then wait for env_out and
  // sample_out to settle before verifying.
  task automatic do_step(input logic g, input string tag);
    gate_in = g;
    step_in = 1'b1;
    model_step();
    tick();
    step_in = 1'b0;
    tick();
    tick();
    tick();
    verify(tag);
    $display("step %-10s gate=%0d state=%0d env=%04h env_out=%02h busy=%0d sample_in=%0d sample_out=%0d",
             tag, g, m_state, m_env[15:0], env_out, busy_out, sample_in, sample_out);
  endtask

  task automatic async_reset(input string tag);
    rst_in = 1'b1;
    model_reset();
    #1;
    check({tag, ".rst_env"},  int'(env_out), 0);
    check({tag, ".rst_busy"}, int'(busy_out), 0);
    check({tag, ".rst_vca"},  int'($signed(sample_out)), 0);
    $display("reset %s env_out=%02h busy=%0d sample_out=%0d", tag, env_out, busy_out, sample_out);
    tick();
    rst_in = 1'b0;
    tick();
  endtask

  // One-cycle gate pulse that lies entirely between two steps.
  task automatic gate_pulse();
    logic keep;
    keep    = gate_in;
    gate_in = ~keep;
    tick();
    gate_in = keep;
    tick();
  endtask

  function automatic logic [15:0] rand_rate();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 16'h0000;
    if (k == 1) return 16'hFFFF;
    if (k < 5)  return 16'($urandom_range(1, 16'h0800));
    return 16'($urandom_range(1, 16'hFFFF));
  endfunction

  initial begin
    rst_in        = 1'b1;
    step_in       = 1'b0;
    gate_in       = 1'b0;
    attack_incr   = 16'h4000;
    decay_decr    = 16'h2000;
    sustain_level = 8'h80;
    release_decr  = 16'h4000;
    sample_in     = 8'sd100;
    model_reset();
    tick();
    tick();
    check("reset.env",  int'(env_out), 0);
    check("reset.busy", int'(busy_out), 0);
    check("reset.vca",  int'($signed(sample_out)), 0);
    rst_in = 1'b0;
    tick();

    // Idle with gate low.
    for (int i = 0; i < 3; i++) do_step(1'b0, "idle");

    // Attack 0x40, 0x80, 0xC0, 0xFF.
    do_step(1'b1, "rise");
    check("rise.busy_const", int'(busy_out), 1);
    do_step(1'b1, "atk1"); check("atk1.const", int'(env_out), 'h40);
    do_step(1'b1, "atk2"); check("atk2.const", int'(env_out), 'h80);
    do_step(1'b1, "atk3"); check("atk3.const", int'(env_out), 'hC0);
    do_step(1'b1, "atk4"); check("atk4.const", int'(env_out), 'hFF);

    // Decay to sustain 0x80: 0xDF, 0xBF, 0x9F, 0x80.
    do_step(1'b1, "dec1"); check("dec1.const", int'(env_out), 'hDF);
    do_step(1'b1, "dec2"); check("dec2.const", int'(env_out), 'hBF);
    do_step(1'b1, "dec3"); check("dec3.const", int'(env_out), 'h9F);
    do_step(1'b1, "dec4"); check("dec4.const", int'(env_out), 'h80);
    do_step(1'b1, "sus");
    sustain_level = 8'h60;
    do_step(1'b1, "sus60"); check("sus60.const", int'(env_out), 'h60);
    sustain_level = 8'h80;
    do_step(1'b1, "sus80");

    // Release to IDLE.
    do_step(1'b0, "fall");
    do_step(1'b0, "rel1"); check("rel1.const", int'(env_out), 'h40);
    do_step(1'b0, "rel2"); check("rel2.const", int'(env_out), 'h00);
    check("rel2.busy_const", int'(busy_out), 0);

    // Legato retrigger from 0x4000.
    do_step(1'b1, "rise2");
    for (int i = 0; i < 4; i++) do_step(1'b1, "atk");
    for (int i = 0; i < 4; i++) do_step(1'b1, "dec");
    do_step(1'b0, "fall2");
    do_step(1'b0, "rel");
    do_step(1'b1, "retrig"); check("retrig.const", int'(env_out), 'h40);
    do_step(1'b1, "retrig1"); check("retrig1.const", int'(env_out), 'h80);
    do_step(1'b1, "retrig2");
    do_step(1'b1, "retrig3"); check("retrig3.const", int'(env_out), 'hFF);

    // VCA with env_out 0xFF held by a zero decay rate.
    decay_decr    = 16'h0000;
    sustain_level = 8'hFF;
    do_step(1'b1, "hold");
    sample_in = 8'sd127;  tick(); tick();
    check("vca.127x255", int'($signed(sample_out)), 126);
    sample_in = -8'sd128; tick(); tick();
    check("vca.-128x255", int'($signed(sample_out)), -128);
    sample_in = -8'sd1;   tick(); tick();
    check("vca.-1x255", int'($signed(sample_out)), -1);

    // env_out 0x80.
    decay_decr    = 16'hFFFF;
    sustain_level = 8'h80;
    do_step(1'b1, "to80");
    sample_in = 8'sd127;  tick(); tick();
    check("vca.127x128", int'($signed(sample_out)), 63);
    sample_in = -8'sd128; tick(); tick();
    check("vca.-128x128", int'($signed(sample_out)), -64);

    // Gate pulse between steps in SUSTAIN is ignored.
    gate_pulse();
    do_step(1'b1, "pulse_sus");

    // Release, then a mid-attack asynchronous reset.
    do_step(1'b0, "fall3");
    do_step(1'b0, "rel");
    do_step(1'b0, "rel");
    attack_incr = 16'h1000;
    do_step(1'b1, "rise3");
    do_step(1'b1, "atk");
    do_step(1'b1, "atk");
    async_reset("midatk");
    do_step(1'b1, "rise_post");
    check("rise_post.busy_const", int'(busy_out), 1);

    // Back to IDLE, then a gate pulse there is ignored.
    release_decr = 16'hFFFF;
    do_step(1'b0, "fall4");
    do_step(1'b0, "rel_fast");
    gate_pulse();
    do_step(1'b0, "pulse_idle");
    check("pulse_idle.busy_const", int'(busy_out), 0);

    // Randomized run.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) attack_incr  = rand_rate();
      if ($urandom_range(0, 3) == 0) decay_decr   = rand_rate();
      if ($urandom_range(0, 3) == 0) release_decr = rand_rate();
      if ($urandom_range(0, 5) == 0) sustain_level = 8'($urandom_range(0, 255));
      sample_in = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) gate_pulse();
      if ($urandom_range(0, 79) == 0) async_reset("rand");
      if ($urandom_range(0, 5) == 0) gate_in = ~gate_in;
      do_step(gate_in, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
